// File: rtl/ndma_pkg.sv
// Shared OBI request/response types and widths for the NanoDMA managers and
// the memory-backed subordinate.
package ndma_pkg;

    localparam int ObiAddrWidth = 32;
    localparam int ObiBeWidth   = 4;
    localparam int ObiDataWidth = 32;

    typedef struct packed {
        logic [ObiAddrWidth-1:0] addr;
        logic                    we;
        logic [ObiBeWidth-1:0]   be;
        logic [ObiDataWidth-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic                    err;
    } obi_rsp_t;

endpackage

// File: rtl/ndma_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy outputs; data_o
// shows the head entry whenever empty_o is low.
module ndma_sync_fifo #(
    parameter int  Depth = 4,
    parameter type T     = logic,
    parameter int  CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  T                data_i,
    input  logic            pop_i,
    output T                data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] usage_o
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    T                mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop_i)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;

    overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && full_o && !pop_i));
    underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop_i && empty_o));

endmodule

// File: rtl/ndma_obi_mem_sub.sv
// OBI subordinate backed by a word array: pipelined accepts up to an outstanding
// limit, fixed-latency pipe, in-order responses through a back-pressurable FIFO.
module ndma_obi_mem_sub
    import ndma_pkg::*;
#(
    parameter int unsigned             Words          = 256,
    parameter logic [ObiAddrWidth-1:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned             Latency        = 2,
    parameter int unsigned             MaxOutstanding = 4,
    parameter int unsigned             DataWidth      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ObiAddrWidth-1:0] addr_i,
    input  logic                    we_i,
    input  logic [ObiBeWidth-1:0]   be_i,
    input  logic [DataWidth-1:0]    wdata_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    err_o
);
    localparam int IdxW = $clog2(Words);
    localparam int CntW = $clog2(MaxOutstanding) + 1;

    obi_req_t                req;
    obi_rsp_t                s0_rsp, out_rsp, head_rsp;
    logic [ObiAddrWidth-1:0] offset;
    logic [IdxW-1:0]         idx;
    logic                    addr_err, accept, pop, out_vld;
    logic [CntW-1:0]         outst_q, outst_d;
    logic                    fifo_full, fifo_empty;
    logic [CntW-1:0]         fifo_usage;

    assign req.addr  = addr_i;
    assign req.we    = we_i;
    assign req.be    = be_i;
    assign req.wdata = wdata_i;

    // Addresses below the base wrap to a huge offset, so one range test covers both ends.
    assign offset   = req.addr - BaseAddr;
    assign idx      = offset[IdxW+1:2];
    assign addr_err = (req.addr[1:0] != 2'b00) || ((offset >> (IdxW + 2)) != '0);

    assign gnt_o  = !rst_i && (outst_q < CntW'(MaxOutstanding));
    assign accept = req_i && gnt_o;

    logic [31:0] mem_q [Words];
    logic [31:0] mem_rd_q;

    always_ff @(posedge clk_i) begin
        if (accept && !addr_err && req.we) begin
            for (int k = 0; k < ObiBeWidth; k++) begin
                if (req.be[k]) mem_q[idx][k*8 +: 8] <= req.wdata[k*8 +: 8];
            end
        end
        mem_rd_q <= mem_q[idx];
    end

    // Stage 0 is the array read register; writes and errors mask its data to zero.
    logic s0_vld_q, s0_vld_d, s0_err_q, s0_err_d, s0_rd_q, s0_rd_d;

    always_comb begin
        s0_vld_d = accept;
        s0_err_d = accept && addr_err;
        s0_rd_d  = accept && !addr_err && !req.we;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_vld_q <= 1'b0;
            s0_err_q <= 1'b0;
            s0_rd_q  <= 1'b0;
        end else begin
            s0_vld_q <= s0_vld_d;
            s0_err_q <= s0_err_d;
            s0_rd_q  <= s0_rd_d;
        end
    end

    assign s0_rsp.rdata = s0_rd_q ? mem_rd_q : 32'd0;
    assign s0_rsp.err   = s0_err_q;

    if (Latency == 1) begin : g_no_tail
        assign out_vld = s0_vld_q;
        assign out_rsp = s0_rsp;
    end else begin : g_tail
        localparam int TailN = Latency - 1;
        logic     vld_q [TailN];
        logic     vld_d [TailN];
        obi_rsp_t rsp_q [TailN];
        obi_rsp_t rsp_d [TailN];

        always_comb begin
            vld_d[0] = s0_vld_q;
            rsp_d[0] = s0_rsp;
            for (int i = 1; i < TailN; i++) begin
                vld_d[i] = vld_q[i-1];
                rsp_d[i] = rsp_q[i-1];
            end
        end

        always_ff @(posedge clk_i) begin
            for (int i = 0; i < TailN; i++) begin
                if (rst_i) begin
                    vld_q[i] <= 1'b0;
                    rsp_q[i] <= '0;
                end else begin
                    vld_q[i] <= vld_d[i];
                    rsp_q[i] <= rsp_d[i];
                end
            end
        end

        assign out_vld = vld_q[TailN-1];
        assign out_rsp = rsp_q[TailN-1];
    end

    ndma_sync_fifo #(
        .Depth (MaxOutstanding),
        .T     (obi_rsp_t),
        .CntW  (CntW)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (out_vld),
        .data_i  (out_rsp),
        .pop_i   (pop),
        .data_o  (head_rsp),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage)
    );

    assign rvalid_o = !fifo_empty && !rst_i;
    assign pop      = rvalid_o && rready_i;
    assign rdata_o  = rvalid_o ? head_rsp.rdata : '0;
    assign err_o    = rvalid_o && head_rsp.err;

    always_comb begin
        outst_d = outst_q;
        case ({accept, pop})
            2'b10:   outst_d = outst_q + CntW'(1);
            2'b01:   outst_d = outst_q - CntW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) outst_q <= '0;
        else       outst_q <= outst_d;
    end

    req_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (req_i && !gnt_o) |=> (req_i && $stable(req)));
    fifo_bound_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (fifo_usage <= outst_q) && !(out_vld && fifo_full && !pop));

endmodule

// File: tb/tb_ndma_obi_mem_sub.sv
// Randomized scoreboard bench for ndma_obi_mem_sub: a word-array model predicts
// each response at acceptance; a negedge monitor checks grant, data and timing.
module tb_ndma_obi_mem_sub;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          WORDS  = 256;
    localparam int          LAT    = 2;
    localparam int          MAXOUT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i, req_i, gnt_o, we_i, rvalid_o, rready_i, err_o;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic [3:0]  be_i;

    ndma_obi_mem_sub #(
        .Words(WORDS), .BaseAddr(BASE), .Latency(LAT), .MaxOutstanding(MAXOUT), .DataWidth(32)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
        .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
        .rready_i(rready_i), .rdata_o(rdata_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [WORDS];
    int          cyc = 0;
    int          checks = 0, errors = 0;
    int          n_acc = 0, n_pop = 0, n_rsp = 0;
    int          prev_pop_edge = 0;
    bit          head_seen = 0;
    int          last_acc = 0;
    bit          stop_toggle = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'(WORDS * 4));
    endfunction

    // Driver: holds the request until granted, then updates the model at the accept edge.
    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d);
        int   waited;
        int   widx;
        exp_t e;
        waited  = 0;
        req_i   = 1'b1;
        addr_i  = a;
        we_i    = w;
        be_i    = b;
        wdata_i = d;
        @(negedge clk_i);
        while (!gnt_o && waited < 300) begin
            @(negedge clk_i);
            waited++;
        end
        if (!gnt_o) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout addr=%08h got gnt=0 expected grant within 300 cycles", a);
            req_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        e.acc   = cyc;
        e.err   = addr_bad(a);
        e.rdata = 32'd0;
        if (!e.err) begin
            widx = int'((a - BASE) >> 2);
            if (w) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) model_mem[widx][8*k +: 8] = d[8*k +: 8];
            end else begin
                e.rdata = model_mem[widx];
            end
        end
        exp_q.push_back(e);
        n_acc++;
        last_acc = cyc;
        req_i = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        rready_i = 1'b1;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk_i);
            w++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending responses expected 0", exp_q.size());
        end
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: grant prediction, response compare, visibility timing.
    initial begin
        exp_t e;
        int   ev;
        logic exp_gnt;
        forever begin
            @(negedge clk_i);
            exp_gnt = !rst_i && ((n_acc - n_pop) < MAXOUT);
            checks++;
            if (gnt_o !== exp_gnt) begin
                errors++;
                $display("FAIL gnt cyc=%0d got %0b expected %0b", cyc, gnt_o, exp_gnt);
            end
            if (rst_i) begin
                checks++;
                if (rvalid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_rvalid cyc=%0d got %0b expected 0", cyc, rvalid_o);
                end
            end else if (rvalid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp cyc=%0d got rvalid=1 expected 0", cyc);
                end else begin
                    e  = exp_q[0];
                    ev = (e.acc + LAT > prev_pop_edge) ? e.acc + LAT : prev_pop_edge;
                    if (!head_seen) begin
                        checks++;
                        if (cyc != ev) begin
                            errors++;
                            $display("FAIL rsp_timing got cyc=%0d expected cyc=%0d", cyc, ev);
                        end
                        head_seen = 1;
                    end
                    checks++;
                    if (rdata_o !== e.rdata || err_o !== e.err) begin
                        errors++;
                        $display("FAIL rsp_data cyc=%0d got rdata=%08h err=%0b expected rdata=%08h err=%0b",
                                 cyc, rdata_o, err_o, e.rdata, e.err);
                    end
                    if (rready_i) begin
                        $display("rsp %0d: rdata=%08h err=%0b acc_cyc=%0d pop_cyc=%0d",
                                 n_rsp, rdata_o, err_o, e.acc, cyc);
                        void'(exp_q.pop_front());
                        n_pop++;
                        n_rsp++;
                        prev_pop_edge = cyc + 1;
                        head_seen = 0;
                    end
                end
            end else if (exp_q.size() != 0) begin
                e  = exp_q[0];
                ev = (e.acc + LAT > prev_pop_edge) ? e.acc + LAT : prev_pop_edge;
                if (cyc >= ev) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_late cyc=%0d got rvalid=0 expected rvalid=1 since cyc=%0d", cyc, ev);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish expected completion within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_acc;
        int r;
        logic [31:0] a;
        rst_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
        rready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        for (int i = 0; i < WORDS; i++) issue(BASE + 32'(i * 4), 1'b1, 4'hF, $urandom());
        drain();

        issue(32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
        issue(32'h10, 1'b0, 4'h0, 32'h0);
        drain();

        issue(32'h20, 1'b1, 4'hF, 32'hAAAAAAAA);
        issue(32'h20, 1'b1, 4'b0101, 32'h11223344);
        issue(32'h20, 1'b0, 4'h0, 32'h0);
        issue(32'h24, 1'b1, 4'h0, 32'h55555555);
        issue(32'h24, 1'b0, 4'h0, 32'h0);
        drain();

        issue(32'h402, 1'b0, 4'h0, 32'h0);
        issue(32'h400, 1'b0, 4'h0, 32'h0);
        issue(32'h3FE, 1'b1, 4'hF, 32'h12345678);
        issue(32'h400, 1'b1, 4'hF, 32'h87654321);
        issue(32'h3FC, 1'b0, 4'h0, 32'h0);
        drain();

        rready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) issue(32'h100 + 32'(i * 4), 1'b0, 4'h0, 32'h0);
            end
            begin
                int w;
                w = 0;
                while (n_acc - n_pop < MAXOUT && w < 50) begin
                    @(posedge clk_i);
                    w++;
                end
                repeat (4) @(posedge clk_i);
                #1;
                checks++;
                if (n_acc - n_pop != MAXOUT) begin
                    errors++;
                    $display("FAIL bp_grants got %0d outstanding expected %0d", n_acc - n_pop, MAXOUT);
                end
                rready_i = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 64; i++) begin
            issue(32'(i * 4), 1'b0, 4'h0, 32'h0);
            if (i == 0) first_acc = last_acc;
        end
        checks++;
        if (last_acc - first_acc != 63) begin
            errors++;
            $display("FAIL stream_gap got %0d cycles for 64 accepts expected 63", last_acc - first_acc);
        end
        drain();

        rready_i = 1'b0;
        for (int i = 0; i < 3; i++) issue(32'h40 + 32'(i * 4), 1'b0, 4'h0, 32'h0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        exp_q.delete();
        n_acc = 0;
        n_pop = 0;
        head_seen = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        rready_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        issue(32'h44, 1'b0, 4'h0, 32'h0);
        drain();

        stop_toggle = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    r = int'($urandom_range(0, 9));
                    if (r < 8)       a = BASE + 32'($urandom_range(0, WORDS - 1) * 4);
                    else if (r == 8) a = BASE + 32'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(1, 3));
                    else             a = BASE + 32'(WORDS * 4) + 32'($urandom_range(0, 1023) * 4);
                    issue(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom());
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk_i);
                        #1;
                    end
                end
                stop_toggle = 1;
            end
            begin
                while (!stop_toggle) begin
                    @(posedge clk_i);
                    #1;
                    rready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
